// File: rtl/serializer_tx_pkg.sv
// Shared definitions for the per-lane transmit serializer.
//
// Contents:
//   COM_SYM    - idle / training symbol (K28.5 low byte), also used by the
//                receive-side deserializer so both ends agree on it.
//   ZERO_SYM   - fill byte shifted out while the lane is off.
//   tx_state_e - lane FSM encoding (OFF=0, TRAIN=1, RUN=2), kept numerically
//                identical to the encoding the receive side expects.
//   com_cnt_width - width of a counter that has to hold 0..min_com.
package serializer_tx_pkg;

  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] ZERO_SYM = 8'h00;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } tx_state_e;

  // Bits needed for a counter that saturates at min_com (never below 1 bit).
  function automatic int com_cnt_width(input int min_com);
    int w;
    w = $clog2(min_com + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serializer_tx_if.sv
// Byte handshake between the TX byte-demux stage (master) and the lane
// serializer (slave).
//
// Signals:
//   data_in   - byte offered by the source
//   valid_in  - data_in is valid; the source holds data_in/valid_in stable
//               until the byte is taken
//   ready_out - serializer takes the byte at this clock edge if valid_in=1
//
// Handshake: a byte moves exactly on a rising clk_32f edge where
// valid_in && ready_out. ready_out never depends on valid_in, so the source
// may wait for ready_out before raising valid_in or raise it early and hold.
interface serializer_tx_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );

endinterface

// File: rtl/serializer_tx.sv
// Per-lane transmit serializer.
//
// Takes bytes over a valid/ready handshake and shifts them out MSB first,
// one bit per clk_32f. On enable it sends a training burst of MIN_COM COM
// symbols before it accepts any data, and while running it fills every byte
// slot that has no offered byte with COM. While disabled it sends zeros.
//
// Ports:
//   clk_32f    in   bit clock, single clock domain
//   reset      in   synchronous, active-high
//   tx_en      in   lane enable
//   bus        slave modport: data_in[7:0], valid_in in, ready_out out
//   serial_out out  serial bit stream (registered, shreg[7])
//   tx_active  out  high while the FSM is in RUN (registered)
//   state_dbg  out  current FSM state, for observation only
//
// Parameters:
//   COM      idle / training symbol
//   MIN_COM  COM symbols sent in TRAIN before data is accepted (>= 1)
module serializer_tx
  import serializer_tx_pkg::*;
#(
  parameter logic [7:0] COM     = COM_SYM,
  parameter int         MIN_COM = 4
) (
  input  logic            clk_32f,
  input  logic            reset,
  input  logic            tx_en,
  serializer_tx_if.slave  bus,
  output logic            serial_out,
  output logic            tx_active,
  output tx_state_e       state_dbg
);

  localparam int              CW        = com_cnt_width(MIN_COM);
  localparam logic [CW-1:0]   MIN_COM_C = CW'(MIN_COM);
  localparam logic [CW-1:0]   ONE_C     = CW'(1);

  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] com_cnt;
  tx_state_e     state;
  logic          boundary;

  // bit_cnt==7 marks the last bit of the current byte; the edge that ends
  // this cycle loads the next byte and advances the FSM. Reset leaves
  // bit_cnt at 7 so the very first edge after reset is a boundary.
  assign boundary      = (bit_cnt == 3'd7);

  // Depends only on registers and tx_en, never on valid_in.
  assign bus.ready_out = (state == ST_RUN) && boundary && tx_en;

  assign serial_out    = shreg[7];
  assign state_dbg     = state;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shreg     <= ZERO_SYM;
      bit_cnt   <= 3'd7;
      com_cnt   <= '0;
      state     <= ST_OFF;
      tx_active <= 1'b0;
    end else if (!boundary) begin
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end else begin
      bit_cnt <= 3'd0;
      unique case (state)
        ST_OFF: begin
          if (tx_en) begin
            shreg   <= COM;
            com_cnt <= ONE_C;
            // A one-symbol training burst is complete with this load.
            if (MIN_COM == 1) begin
              state     <= ST_RUN;
              tx_active <= 1'b1;
            end else begin
              state     <= ST_TRAIN;
              tx_active <= 1'b0;
            end
          end else begin
            shreg     <= ZERO_SYM;
            com_cnt   <= '0;
            tx_active <= 1'b0;
          end
        end

        ST_TRAIN: begin
          if (!tx_en) begin
            shreg     <= ZERO_SYM;
            com_cnt   <= '0;
            state     <= ST_OFF;
            tx_active <= 1'b0;
          end else begin
            shreg <= COM;
            // com_cnt counts COMs already loaded; this load is one more.
            if (com_cnt + ONE_C >= MIN_COM_C) begin
              com_cnt   <= MIN_COM_C;
              state     <= ST_RUN;
              tx_active <= 1'b1;
            end else begin
              com_cnt <= com_cnt + ONE_C;
            end
          end
        end

        ST_RUN: begin
          if (!tx_en) begin
            // The byte just finished was completed in full; now go quiet.
            shreg     <= ZERO_SYM;
            com_cnt   <= '0;
            state     <= ST_OFF;
            tx_active <= 1'b0;
          end else if (bus.valid_in) begin
            // Sent verbatim, even if the byte equals COM.
            shreg <= bus.data_in;
          end else begin
            shreg <= COM;
          end
        end

        default: begin
          shreg     <= ZERO_SYM;
          com_cnt   <= '0;
          state     <= ST_OFF;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
